data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 38 +++
 rtl/data_mem_arb_pick.sv | 63 ++++++
 rtl/data_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared definitions for the two-port DataMemory arbiter:
//   - arb_state_e : FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - PORT0/PORT1 : requester index constants used by the pick logic
//   - RD_LATENCY_MIN/RD_LATENCY_MAX and the wait-counter width that covers them
//   - clampLatency: folds an out-of-range read latency into the legal range
// No ports; imported by data_mem_arbiter and data_mem_arb_pick.
// ---------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 7;
    localparam int LAT_CNT_W      = 3;

    // A latency outside 1..7 cannot be counted by the 3-bit wait counter,
    // so it is pinned to the nearest legal value instead.
    function automatic int clampLatency(input int lat);
        if (lat < RD_LATENCY_MIN) begin
            return RD_LATENCY_MIN;
        end
        if (lat > RD_LATENCY_MAX) begin
            return RD_LATENCY_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/data_mem_arb_pick.sv
// ---------------------------------------------------------------------------
// data_mem_arb_pick
// Winner selection between requester 0 and requester 1.
// Macro DATA_MEM_ARB_ROUND_ROBIN_EN:
//   defined   - on a tie the port that did not win last is picked; the
//               last-winner pointer is updated on every grant and resets to
//               PORT1 so that port 0 wins the first tie.
//   undefined - fixed priority, port 0 wins every tie; no pointer state and
//               no clock/reset ports.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset (round-robin only)
//   upd_i            a grant is being issued this cycle (round-robin only)
//   upd_idx_i        index of the port being granted (round-robin only)
//   req0_i, req1_i   requests from port 0 / port 1
//   pick_o           selected port index (meaningful when any request is high)
// ---------------------------------------------------------------------------
module data_mem_arb_pick
    import data_mem_arbiter_pkg::*;
(
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    input  logic clk_i,
    input  logic reset_i,
    input  logic upd_i,
    input  logic upd_idx_i,
`endif
    input  logic req0_i,
    input  logic req1_i,
    output logic pick_o
);

`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
    logic lastWin_q;

    // Remember which port was granted most recently so a tie can go the
    // other way next time.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lastWin_q <= PORT1;
        end else if (upd_i) begin
            lastWin_q <= upd_idx_i;
        end
    end

    // A lone requester always wins; a tie goes to the port that lost last.
    always_comb begin
        pick_o = PORT0;
        if (req0_i && req1_i) begin
            pick_o = ~lastWin_q;
        end else if (req1_i) begin
            pick_o = PORT1;
        end
    end
`else
    // Fixed priority: port 1 is only chosen when port 0 is not asking.
    always_comb begin
        pick_o = PORT0;
        if (!req0_i && req1_i) begin
            pick_o = PORT1;
        end
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Two-requester arbiter in front of a single DataMemory. Exactly one command
// is in flight at a time: IDLE picks and latches a request, ISSUE drives the
// memory strobe and grant for one cycle, WAIT counts RD_LATENCY cycles and
// captures R_DATA, RESP pulses the read-valid of the winning port.
// Tie-breaking is selected by macro DATA_MEM_ARB_ROUND_ROBIN_EN (see
// data_mem_arb_pick); the default build uses fixed priority to port 0.
// Parameters: ADDR_W, DATA_W, RD_LATENCY (1..7).
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req0_i/req1_i, we0_i/we1_i     request and write-enable per port
//   addr0_i/addr1_i, wdata0_i/wdata1_i  address and write data per port
//   gnt0_o/gnt1_o                  one-cycle command-issued pulse
//   rvalid0_o/rvalid1_o            one-cycle read-data-valid pulse
//   rdata0_o/rdata1_o              last read data returned to each port
//   mrd_o, mwrt_o, addr_o, w_data_o, r_data_i  DataMemory interface
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mrd_o,
    output logic              mwrt_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] w_data_o,
    input  logic [DATA_W-1:0] r_data_i
);

    localparam int                   LAT     = clampLatency(RD_LATENCY);
    localparam logic [LAT_CNT_W-1:0] LAT_CNT = LAT_CNT_W'(LAT);

    arb_state_e           state_q, state_d;
    logic                 win_q, win_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata0_q, rdata0_d;
    logic [DATA_W-1:0]    rdata1_q, rdata1_d;
    logic                 pick;

    data_mem_arb_pick u_pick (
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .upd_i     (gnt0_o | gnt1_o),
        .upd_idx_i (win_q),
`endif
        .req0_i    (req0_i),
        .req1_i    (req1_i),
        .pick_o    (pick)
    );

    // State and latched command registers. Reset drops any access in
    // progress and clears the per-port read data.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            win_q    <= PORT0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state and output decode. Strobes, grants and read-valids are
    // forced low while reset is high so that an aborted access produces no
    // pulse even in the cycle reset is first seen.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        gnt0_o    = 1'b0;
        gnt1_o    = 1'b0;
        rvalid0_o = 1'b0;
        rvalid1_o = 1'b0;
        mrd_o     = 1'b0;
        mwrt_o    = 1'b0;
        addr_o    = '0;
        w_data_o  = '0;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    win_d = pick;
                    if (pick == PORT1) begin
                        we_d    = we1_i;
                        addr_d  = addr1_i;
                        wdata_d = wdata1_i;
                    end else begin
                        we_d    = we0_i;
                        addr_d  = addr0_i;
                        wdata_d = wdata0_i;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mrd_o    = ~we_q;
                mwrt_o   = we_q;
                addr_o   = addr_q;
                w_data_o = wdata_q;
                gnt0_o   = (win_q == PORT0);
                gnt1_o   = (win_q == PORT1);
                cnt_d    = LAT_CNT_W'(1);
                state_d  = we_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt_q == LAT_CNT) begin
                    if (win_q == PORT1) begin
                        rdata1_d = r_data_i;
                    end else begin
                        rdata0_d = r_data_i;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rvalid0_o = (win_q == PORT0);
                rvalid1_o = (win_q == PORT1);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset_i) begin
            gnt0_o    = 1'b0;
            gnt1_o    = 1'b0;
            rvalid0_o = 1'b0;
            rvalid1_o = 1'b0;
            mrd_o     = 1'b0;
            mwrt_o    = 1'b0;
            addr_o    = '0;
            w_data_o  = '0;
        end
    end

    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter (ADDR_W=DATA_W=32, RD_LATENCY=1) with a
// small registered memory model behind it. Arbitration expectations follow
// macro DATA_MEM_ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

    typedef struct {
        int          gntAt;
        int          rvAt;
        logic [31:0] rd;
        logic        mrd;
        logic        mwrt;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          overlap;
        bit          otherPulse;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mrd, mwrt;
    logic [31:0] memAddr, wData, rData;
    logic [31:0] mem [0:63];

    int checks = 0;
    int fails  = 0;

    data_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RD_LATENCY (1)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .req0_i    (req0),
        .req1_i    (req1),
        .we0_i     (we0),
        .we1_i     (we1),
        .addr0_i   (addr0),
        .addr1_i   (addr1),
        .wdata0_i  (wdata0),
        .wdata1_i  (wdata1),
        .gnt0_o    (gnt0),
        .gnt1_o    (gnt1),
        .rvalid0_o (rvalid0),
        .rvalid1_o (rvalid1),
        .rdata0_o  (rdata0),
        .rdata1_o  (rdata1),
        .mrd_o     (mrd),
        .mwrt_o    (mwrt),
        .addr_o    (memAddr),
        .w_data_o  (wData),
        .r_data_i  (rData)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes land on the strobe edge, read data appears one
    // cycle after MRd, matching RD_LATENCY=1.
    always @(posedge clk) begin
        if (mwrt) begin
            mem[memAddr[5:0]] <= wData;
        end
        if (mrd) begin
            rData <= mem[memAddr[5:0]];
        end
    end

    // Issue one access on a port, hold it until granted, and record what the
    // DUT did. Cycle 0 is the IDLE cycle in which the request is first seen.
    task automatic applyStimulus(input logic port, input logic we,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output obs_t o);
        o.gntAt = -1; o.rvAt = -1; o.rd = '0; o.mrd = 1'b0; o.mwrt = 1'b0;
        o.addr = '0; o.wdata = '0; o.overlap = 1'b0; o.otherPulse = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if ((gnt0 && gnt1) || (rvalid0 && rvalid1) || (mrd && mwrt)) o.overlap = 1'b1;
            if ((port ? gnt0 : gnt1) || (port ? rvalid0 : rvalid1)) o.otherPulse = 1'b1;
            if ((port ? gnt1 : gnt0) && o.gntAt < 0) begin
                o.gntAt = cyc; o.mrd = mrd; o.mwrt = mwrt; o.addr = memAddr; o.wdata = wData;
            end
            if ((port ? rvalid1 : rvalid0) && o.rvAt < 0) begin
                o.rvAt = cyc; o.rd = port ? rdata1 : rdata0;
            end
            if (we && o.gntAt >= 0 && cyc > o.gntAt) break;
            if (!we && o.rvAt >= 0) break;
            @(posedge clk); #1;
            if (o.gntAt >= 0) begin
                if (port) req1 = 1'b0; else req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    // Hold reset for ten cycles and confirm every output is quiet.
    task automatic test_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mrd, mwrt} !== 6'b0) begin
            fails++; $display("[TB] FAIL reset_pulses: got %b expected 000000", {gnt0, gnt1, rvalid0, rvalid1, mrd, mwrt});
        end
        checks++;
        if (memAddr !== 32'd0) begin fails++; $display("[TB] FAIL reset_addr: got %0h expected 0", memAddr); end
        checks++;
        if (wData !== 32'd0) begin fails++; $display("[TB] FAIL reset_wdata: got %0h expected 0", wData); end
        checks++;
        if (rdata0 !== 32'd0) begin fails++; $display("[TB] FAIL reset_rdata0: got %0h expected 0", rdata0); end
        checks++;
        if (rdata1 !== 32'd0) begin fails++; $display("[TB] FAIL reset_rdata1: got %0h expected 0", rdata1); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Port 0 writes 52 to address 4.
    task automatic test_write();
        obs_t o;
        applyStimulus(1'b0, 1'b1, 32'd4, 32'd52, o);
        checks++;
        if (o.gntAt !== 1) begin fails++; $display("[TB] FAIL write_gnt_cycle: got %0d expected 1", o.gntAt); end
        checks++;
        if ({o.mwrt, o.mrd} !== 2'b10) begin fails++; $display("[TB] FAIL write_strobes: got mwrt/mrd %b expected 10", {o.mwrt, o.mrd}); end
        checks++;
        if (o.addr !== 32'd4) begin fails++; $display("[TB] FAIL write_addr: got %0d expected 4", o.addr); end
        checks++;
        if (o.wdata !== 32'd52) begin fails++; $display("[TB] FAIL write_data: got %0d expected 52", o.wdata); end
        checks++;
        if (o.rvAt !== -1 || o.otherPulse || o.overlap) begin
            fails++; $display("[TB] FAIL write_no_rvalid: got rvAt=%0d other=%0b overlap=%0b expected -1/0/0", o.rvAt, o.otherPulse, o.overlap);
        end
    endtask

    // Port 1 reads back address 4; data must return three cycles later.
    task automatic test_read();
        obs_t o;
        applyStimulus(1'b1, 1'b0, 32'd4, 32'd0, o);
        checks++;
        if (o.gntAt !== 1) begin fails++; $display("[TB] FAIL read_gnt_cycle: got %0d expected 1", o.gntAt); end
        checks++;
        if ({o.mrd, o.mwrt} !== 2'b10 || o.addr !== 32'd4) begin
            fails++; $display("[TB] FAIL read_strobe: got mrd/mwrt %b addr %0d expected 10 addr 4", {o.mrd, o.mwrt}, o.addr);
        end
        checks++;
        if (o.rvAt !== 3) begin fails++; $display("[TB] FAIL read_rvalid_cycle: got %0d expected 3", o.rvAt); end
        checks++;
        if (o.rd !== 32'd52) begin fails++; $display("[TB] FAIL read_data: got %0d expected 52", o.rd); end
        checks++;
        if (o.otherPulse || o.overlap) begin
            fails++; $display("[TB] FAIL read_port_isolation: got other=%0b overlap=%0b expected 0/0", o.otherPulse, o.overlap);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rdata1 !== 32'd52) begin fails++; $display("[TB] FAIL read_hold: got %0d expected 52", rdata1); end
        checks++;
        if (rdata0 !== 32'd0) begin fails++; $display("[TB] FAIL read_rdata0_untouched: got %0d expected 0", rdata0); end
    endtask

    // Both ports hold read requests; record the order of the first grants.
    task automatic test_arbitration();
        int order [4];
        int n = 0;
        int gnt1Count = 0;
        bit ov = 1'b0;
        int expOrder;
        for (int k = 0; k < 4; k++) order[k] = -1;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if ((gnt0 && gnt1) || (rvalid0 && rvalid1) || (mrd && mwrt)) ov = 1'b1;
            if (gnt1) gnt1Count++;
            if (gnt0) begin order[n] = 0; n++; end
            else if (gnt1) begin order[n] = 1; n++; end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) @(posedge clk);
        checks++;
        if (n !== 4) begin fails++; $display("[TB] FAIL arb_grant_count: got %0d expected 4", n); end
        for (int k = 0; k < 4; k++) begin
`ifdef DATA_MEM_ARB_ROUND_ROBIN_EN
            expOrder = k % 2;
`else
            expOrder = 0;
`endif
            checks++;
            if (order[k] !== expOrder) begin
                fails++; $display("[TB] FAIL arb_order[%0d]: got %0d expected %0d", k, order[k], expOrder);
            end
        end
`ifndef DATA_MEM_ARB_ROUND_ROBIN_EN
        checks++;
        if (gnt1Count !== 0) begin fails++; $display("[TB] FAIL arb_fixed_no_gnt1: got %0d expected 0", gnt1Count); end
`endif
        checks++;
        if (ov) begin fails++; $display("[TB] FAIL arb_overlap: got 1 expected 0"); end
    endtask

    // Reset lands in the WAIT cycle of a port 0 read; the read must vanish
    // and a fresh request must still be served normally.
    task automatic test_reset_abort();
        obs_t o;
        int stray = 0;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin fails++; $display("[TB] FAIL abort_gnt: got %b expected 1", gnt0); end
        @(posedge clk); #1;
        req0 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mrd, mwrt} !== 6'b0 || memAddr !== 32'd0 || wData !== 32'd0) begin
            fails++; $display("[TB] FAIL abort_outputs: got %b addr %0h wdata %0h expected zeros", {gnt0, gnt1, rvalid0, rvalid1, mrd, mwrt}, memAddr, wData);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1 || rvalid0 || rvalid1 || mrd || mwrt) stray++;
        end
        checks++;
        if (stray !== 0) begin fails++; $display("[TB] FAIL abort_no_pulse: got %0d stray cycles expected 0", stray); end
        checks++;
        if (rdata0 !== 32'd0) begin fails++; $display("[TB] FAIL abort_rdata0_cleared: got %0d expected 0", rdata0); end
        applyStimulus(1'b0, 1'b0, 32'd4, 32'd0, o);
        checks++;
        if (o.gntAt !== 1 || o.rvAt !== 3) begin
            fails++; $display("[TB] FAIL abort_recover_timing: got gnt %0d rv %0d expected 1/3", o.gntAt, o.rvAt);
        end
        checks++;
        if (o.rd !== 32'd52) begin fails++; $display("[TB] FAIL abort_recover_data: got %0d expected 52", o.rd); end
    endtask

    // Fill addresses 0..31 through port 0, then read 0..14 through port 1.
    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(i), 32'(i * 13), o);
            checks++;
            if (o.gntAt !== 1 || o.mwrt !== 1'b1 || o.mrd !== 1'b0 || o.addr !== 32'(i) || o.wdata !== 32'(i * 13) || o.overlap) begin
                fails++; $display("[TB] FAIL b2b_write[%0d]: got gnt %0d mwrt %b mrd %b addr %0d data %0d ov %b expected 1 1 0 %0d %0d 0",
                                  i, o.gntAt, o.mwrt, o.mrd, o.addr, o.wdata, o.overlap, i, i * 13);
            end
        end
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i), 32'd0, o);
            checks++;
            if (o.rd !== 32'(i * 13) || o.rvAt !== 3 || o.overlap || o.otherPulse) begin
                fails++; $display("[TB] FAIL b2b_read[%0d]: got data %0d rv %0d ov %b other %b expected %0d 3 0 0",
                                  i, o.rd, o.rvAt, o.overlap, o.otherPulse, i * 13);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rdata1 !== 32'd182) begin fails++; $display("[TB] FAIL b2b_final_rdata1: got %0d expected 182", rdata1); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
